// File: rtl/kernel_nios2_oci_pkg.sv
// Shared types and jdo field positions for the Nios II OCI monitor memory engine.
package kernel_nios2_oci_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    JRD  = 3'd1,
    JCAP = 3'd2,
    JWR  = 3'd3,
    CRD  = 3'd4
  } mon_state_e;

  localparam int JDO_RDGO   = 35;
  localparam int JDO_ERRCLR = 36;
  localparam int JDO_WD_LSB = 3;
  localparam int OCI_DATA_W = 32;

  // Even parity: stored bit makes the 9-bit lane have an even count of ones.
  function automatic logic [3:0] byte_parity(input logic [OCI_DATA_W-1:0] d);
    for (int i = 0; i < 4; i++) byte_parity[i] = ^d[8*i +: 8];
  endfunction

endpackage

// File: rtl/kernel_nios2_oci_ram.sv
// Single-port synchronous monitor RAM: byte-lane write enables, 1-cycle read latency.
module kernel_nios2_oci_ram #(
  parameter int ADDR_W = 8,
  parameter int LANE_W = 8
) (
  input  logic                   clk,
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   we,
  input  logic [3:0]             be,
  input  logic [3:0][LANE_W-1:0] wdata,
  output logic [3:0][LANE_W-1:0] q
);

  logic [3:0][LANE_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][i] <= wdata[i];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/kernel_nios2_oci_mon_mem.sv
// JTAG/CPU monitor memory engine; JTAG has priority over the Avalon slave.
// Define OCIMEM_PARITY_EN to store and check one even-parity bit per byte.
module kernel_nios2_oci_mon_mem
  import kernel_nios2_oci_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  input  logic              debugaccess,
  output logic [DATA_W-1:0] readdata,
  output logic              waitrequest,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

`ifdef OCIMEM_PARITY_EN
  localparam int LANE_W = 9;
  typedef logic [3:0][LANE_W-1:0] lanes_t;

  function automatic lanes_t pack_word(input logic [OCI_DATA_W-1:0] d);
    logic [3:0] p;
    p = byte_parity(d);
    for (int i = 0; i < 4; i++) pack_word[i] = {p[i], d[8*i +: 8]};
  endfunction

  function automatic logic [OCI_DATA_W-1:0] unpack_word(input lanes_t w);
    for (int i = 0; i < 4; i++) unpack_word[8*i +: 8] = w[i][7:0];
  endfunction

  function automatic logic parity_bad(input lanes_t w);
    parity_bad = 1'b0;
    for (int i = 0; i < 4; i++) parity_bad |= (w[i][8] != ^w[i][7:0]);
  endfunction
`else
  localparam int LANE_W = 8;
  typedef logic [3:0][LANE_W-1:0] lanes_t;

  function automatic lanes_t pack_word(input logic [OCI_DATA_W-1:0] d);
    pack_word = d;
  endfunction

  function automatic logic [OCI_DATA_W-1:0] unpack_word(input lanes_t w);
    unpack_word = w;
  endfunction
`endif

  mon_state_e              state, state_nxt;
  logic [ADDR_W-1:0]       mon_a_reg;
  logic [OCI_DATA_W-1:0]   mon_d_reg;
  logic                    mon_err;
  logic                    rst_wait;
  logic [OCI_DATA_W-1:0]   wr_data_p0;
  logic                    pend_b, pend_a, pend_na;
  logic [37:0]             pend_jdo;

  logic                    use_pend, live_any, multi_eff;
  logic                    eff_b, eff_a, eff_na;
  logic [37:0]             eff_jdo;
  logic                    acc_b, acc_a, acc_na, hold, err_set, err_clr;
  logic                    cpu_req, wait_req;
  logic [ADDR_W-1:0]       ram_addr;
  logic                    ram_we;
  logic [3:0]              ram_be;
  lanes_t                  ram_wdata, ram_q;
  logic [OCI_DATA_W-1:0]   q_data;
  logic                    q_par_err;
  logic                    unused_jdo;

  // A command that arrived during CRD is replayed from the pending latch in the next IDLE cycle.
  assign use_pend  = pend_b | pend_a | pend_na;
  assign live_any  = take_action_ocimem_b | take_action_ocimem_a | take_no_action_ocimem_a;
  assign eff_b     = use_pend ? pend_b  : take_action_ocimem_b;
  assign eff_a     = use_pend ? pend_a  : take_action_ocimem_a;
  assign eff_na    = use_pend ? pend_na : take_no_action_ocimem_a;
  assign eff_jdo   = use_pend ? pend_jdo : jdo;
  assign multi_eff = (eff_b & eff_a) | (eff_b & eff_na) | (eff_a & eff_na);
  assign cpu_req   = chipselect & (read | write);
  assign q_data    = unpack_word(ram_q);
  assign unused_jdo = ^{eff_jdo[37], eff_jdo[1:0]};

`ifdef OCIMEM_PARITY_EN
  assign q_par_err = parity_bad(ram_q);
`else
  assign q_par_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    ram_addr  = mon_a_reg;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = pack_word(wr_data_p0);
    wait_req  = 1'b1;
    acc_b     = 1'b0;
    acc_a     = 1'b0;
    acc_na    = 1'b0;
    hold      = 1'b0;
    case (state)
      IDLE: begin
        if (use_pend || live_any) begin
          if (eff_b) begin
            acc_b     = 1'b1;
            state_nxt = JWR;
          end else if (eff_a) begin
            acc_a = 1'b1;
            if (eff_jdo[JDO_RDGO]) state_nxt = JRD;
          end else begin
            acc_na    = 1'b1;
            state_nxt = JRD;
          end
        end else if (cpu_req && !rst_wait) begin
          ram_addr = address;
          if (read) begin
            state_nxt = CRD;
          end else begin
            wait_req  = 1'b0;
            ram_we    = debugaccess;
            ram_be    = byteenable;
            ram_wdata = pack_word(writedata);
          end
        end else begin
          wait_req = rst_wait;
        end
      end
      JRD:  state_nxt = JCAP;
      JCAP: state_nxt = IDLE;
      JWR: begin
        ram_we    = 1'b1;
        state_nxt = IDLE;
      end
      CRD: begin
        wait_req  = 1'b0;
        hold      = live_any;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    err_clr = acc_a & eff_jdo[JDO_ERRCLR];
    err_set = ((state == JRD || state == JCAP || state == JWR) && live_any)
           || ((state == IDLE) && (multi_eff || (use_pend && live_any)))
           || ((state == JCAP || state == CRD) && q_par_err);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      mon_a_reg <= '0;
      mon_d_reg <= '0;
      mon_err   <= 1'b0;
      rst_wait  <= 1'b1;
      pend_b    <= 1'b0;
      pend_a    <= 1'b0;
      pend_na   <= 1'b0;
    end else begin
      state    <= state_nxt;
      rst_wait <= 1'b0;
      pend_b   <= hold & take_action_ocimem_b;
      pend_a   <= hold & take_action_ocimem_a;
      pend_na  <= hold & take_no_action_ocimem_a;
      if (acc_a)                        mon_a_reg <= eff_jdo[ADDR_W+1:2];
      else if (acc_na || state == JWR)  mon_a_reg <= mon_a_reg + 1'b1;
      if (state == JCAP)                mon_d_reg <= q_data;
      if (err_set)                      mon_err <= 1'b1;
      else if (err_clr)                 mon_err <= 1'b0;
    end
  end

  // Data-only captures: qualified by control, never read before being written.
  always_ff @(posedge clk) begin
    if (acc_b) wr_data_p0 <= eff_jdo[JDO_WD_LSB +: OCI_DATA_W];
    if (hold)  pend_jdo   <= jdo;
  end

  kernel_nios2_oci_ram #(
    .ADDR_W (ADDR_W),
    .LANE_W (LANE_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

  assign readdata      = (state == CRD) ? q_data : '0;
  assign waitrequest   = wait_req;
  assign MonDReg       = mon_d_reg;
  assign monitor_ready = (state == IDLE);
  assign monitor_error = mon_err;

endmodule
